// File: rtl/spi_alu_pkg.sv
// Shared types, widths and the ALU function for the ALU-over-SPI responder.
package spi_alu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    AND = 2'd2,
    OR  = 2'd3
  } opcode_e;

  localparam int CMD_BITS = 8;
  localparam int RES_BITS = 4;

  // 3-bit unsigned operands, 4-bit result; SUB wraps modulo 16.
  function automatic logic [RES_BITS-1:0] alu_calc(input opcode_e op,
                                                   input logic [2:0] a,
                                                   input logic [2:0] b);
    logic [RES_BITS-1:0] r;
    case (op)
      ADD:     r = {1'b0, a} + {1'b0, b};
      SUB:     r = {1'b0, a} - {1'b0, b};
      AND:     r = {1'b0, a & b};
      OR:      r = {1'b0, a | b};
      default: r = 4'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spi_alu_slave_if.sv
// SPI pin bundle between an SPI master and the ALU responder.
interface spi_alu_slave_if;
  logic sclk;
  logic cs;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs, output mosi, input miso);
  modport slave  (input sclk, input cs, input mosi, output miso);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin, with optional
// one-clk rise/fall pulses taken from the synchronized level.
module spi_sync_edge #(
  parameter int STAGES = 2,
  parameter bit EDGES  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw pin into the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
  end

  // Synchronizer flops; reset low so a pin already low at release gives no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign level = sync_q[STAGES-1];

  generate
    if (EDGES) begin : g_edge
      logic prev_q;
      logic prev_d;

      // Previous synchronized level for edge comparison.
      always_comb begin
        prev_d = sync_q[STAGES-1];
      end

      // Delay flop for the edge detector.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_q <= 1'b0;
        end else begin
          prev_q <= prev_d;
        end
      end

      assign rise = sync_q[STAGES-1] & ~prev_q;
      assign fall = ~sync_q[STAGES-1] & prev_q;
    end else begin : g_level_only
      assign rise = 1'b0;
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_alu_slave.sv
// SPI responder: receives {op, a, b} LSB first, computes a 4-bit result and
// shifts it back on miso after one turnaround sclk edge.
// Optional feature macro: SPI_ALU_ERRCNT_EN adds the saturating err_cnt output.
module spi_alu_slave
  import spi_alu_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_alu_slave_if.slave      spi,
  output logic                result_valid,
  output logic [1:0]          op_q,
  output logic [2:0]          a_q,
  output logic [2:0]          b_q,
  output logic [RES_BITS-1:0] result_q,
  output logic                frame_err
`ifdef SPI_ALU_ERRCNT_EN
  ,
  output logic [7:0]          err_cnt
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RX   = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_TURN = 3'd3;
  localparam logic [2:0] S_TX   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s, mosi_s;
  logic sclk_lvl_unused_s, cs_lvl_unused_s, mosi_rise_unused_s, mosi_fall_unused_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .EDGES(1'b1)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(spi.sclk),
    .level(sclk_lvl_unused_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .EDGES(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(spi.cs),
    .level(cs_lvl_unused_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .EDGES(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(spi.mosi),
    .level(mosi_s), .rise(mosi_rise_unused_s), .fall(mosi_fall_unused_s)
  );

  logic [2:0]          state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [CMD_BITS-1:0] shreg_q, shreg_d;
  logic                miso_q, miso_d;
  logic                result_valid_q, result_valid_d;
  logic                frame_err_q, frame_err_d;
  logic [1:0]          op_d;
  logic [2:0]          a_d, b_d;
  logic [RES_BITS-1:0] result_d;

  // Frame FSM: shift in command, compute, shift out result, handle aborts.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shreg_d        = shreg_q;
    miso_d         = miso_q;
    result_valid_d = 1'b0;
    frame_err_d    = 1'b0;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    result_d       = result_q;
    case (state_q)
      S_IDLE: begin
        cnt_d  = 3'd0;
        miso_d = 1'b0;
        if (cs_fall_s) begin
          state_d = S_RX;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RX: begin
        if (cs_rise_s) begin
          state_d     = S_IDLE;
          miso_d      = 1'b0;
          frame_err_d = 1'b1;
        end else if (sclk_fall_s) begin
          shreg_d[cnt_q] = mosi_s;
          cnt_d          = cnt_q + 3'd1;
          if (cnt_q == 3'(CMD_BITS - 1)) begin
            state_d = S_CALC;
          end else begin
            state_d = S_RX;
          end
        end else begin
          state_d = S_RX;
        end
      end
      S_CALC: begin
        // result_valid has not fired yet, so an abort here is still an error.
        if (cs_rise_s) begin
          state_d     = S_IDLE;
          miso_d      = 1'b0;
          frame_err_d = 1'b1;
        end else begin
          op_d           = shreg_q[7:6];
          a_d            = shreg_q[5:3];
          b_d            = shreg_q[2:0];
          result_d       = alu_calc(opcode_e'(shreg_q[7:6]), shreg_q[5:3], shreg_q[2:0]);
          result_valid_d = 1'b1;
          state_d        = S_TURN;
        end
      end
      S_TURN: begin
        if (cs_rise_s) begin
          state_d = S_IDLE;
          miso_d  = 1'b0;
        end else if (sclk_rise_s) begin
          miso_d  = result_q[0];
          cnt_d   = 3'd1;
          state_d = S_TX;
        end else begin
          state_d = S_TURN;
        end
      end
      S_TX: begin
        if (cs_rise_s) begin
          state_d = S_IDLE;
          miso_d  = 1'b0;
        end else if (sclk_rise_s) begin
          miso_d = result_q[cnt_q[1:0]];
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'(RES_BITS - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_TX;
          end
        end else begin
          state_d = S_TX;
        end
      end
      S_DONE: begin
        if (cs_rise_s) begin
          state_d = S_IDLE;
          miso_d  = 1'b0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        miso_d  = 1'b0;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= 3'd0;
      shreg_q        <= '0;
      miso_q         <= 1'b0;
      result_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
      op_q           <= 2'd0;
      a_q            <= 3'd0;
      b_q            <= 3'd0;
      result_q       <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shreg_q        <= shreg_d;
      miso_q         <= miso_d;
      result_valid_q <= result_valid_d;
      frame_err_q    <= frame_err_d;
      op_q           <= op_d;
      a_q            <= a_d;
      b_q            <= b_d;
      result_q       <= result_d;
    end
  end

  assign spi.miso     = miso_q;
  assign result_valid = result_valid_q;
  assign frame_err    = frame_err_q;

`ifdef SPI_ALU_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Count frame errors, saturating at 255.
  always_comb begin
    if (frame_err_q && (err_cnt_q != 8'd255)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
